// File: rtl/fifo_pkg.sv
// Shared asynchronous FIFO definitions: default pointer width and the Gray/binary
// conversions used by both the read- and write-domain pointer controllers.
package fifo_pkg;

  localparam int FIFO_PTR_WIDTH = 4;
  localparam int PTR_W1         = FIFO_PTR_WIDTH + 1;

  function automatic logic [PTR_W1-1:0] bin2gray(input logic [PTR_W1-1:0] v);
    return (v >> 1) ^ v;
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [PTR_W1-1:0] gray2bin(input logic [PTR_W1-1:0] v);
    logic [PTR_W1-1:0] b;
    b[PTR_W1-1] = v[PTR_W1-1];
    for (int i = PTR_W1 - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ v[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for Gray-coded pointers crossing into another clock domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1 <= '0;
      q      <= '0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/rptr_empty_ctrl.sv
// Read-domain pointer controller: advances the read pointers on accepted reads and
// derives registered empty/almost_empty/occupancy from the synchronised write pointer.
module rptr_empty_ctrl
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH = fifo_pkg::FIFO_PTR_WIDTH,
  parameter int AE_THRESH = 2
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 ren,
  input  logic                 clr_underflow,
  input  logic [PTR_WIDTH:0]   wptr_gray,
  output logic [PTR_WIDTH:0]   rptr_bin,
  output logic [PTR_WIDTH:0]   rptr_gray,
  output logic [PTR_WIDTH-1:0] raddr,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   rd_count,
  output logic                 underflow,
  output logic                 underflow_sticky
);

  localparam logic [PTR_WIDTH:0] AE_LIMIT = AE_THRESH[PTR_WIDTH:0];

  logic [PTR_WIDTH:0] wq2_wptr_gray;
  logic [PTR_WIDTH:0] wbin_sync;
  logic [PTR_WIDTH:0] rbin_next;
  logic [PTR_WIDTH:0] rgray_next;
  logic [PTR_WIDTH:0] count_next;
  logic               rd_fire;

  sync_2ff #(.WIDTH(PTR_WIDTH + 1)) u_wptr_sync (
    .clk (rclk),
    .rst (rrst),
    .d   (wptr_gray),
    .q   (wq2_wptr_gray)
  );

  // Flags and count are computed from the post-read pointer so that the read
  // draining the last entry raises empty on its own edge.
  always_comb begin
    rd_fire    = ren && !empty;
    rbin_next  = rptr_bin + {{PTR_WIDTH{1'b0}}, rd_fire};
    rgray_next = bin2gray(rbin_next);
    wbin_sync  = gray2bin(wq2_wptr_gray);
    count_next = wbin_sync - rbin_next;
  end

  assign raddr     = rptr_bin[PTR_WIDTH-1:0];
  assign underflow = ren && empty;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rptr_bin     <= '0;
      rptr_gray    <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
    end else begin
      rptr_bin     <= rbin_next;
      rptr_gray    <= rgray_next;
      empty        <= (rgray_next == wq2_wptr_gray);
      almost_empty <= (count_next <= AE_LIMIT);
      rd_count     <= count_next;
    end
  end

  // A fresh underflow outranks a simultaneous clear so no event is lost.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      underflow_sticky <= 1'b0;
    end else if (underflow) begin
      underflow_sticky <= 1'b1;
    end else if (clr_underflow) begin
      underflow_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Self-checking bench for rptr_empty_ctrl: occupancy model plus directed scenarios.
module tb_rptr_empty_ctrl;

  localparam int PW   = 4;
  localparam int AE   = 2;
  localparam int MASK = (1 << (PW + 1)) - 1;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          ren = 1'b0;
  logic          clr_underflow = 1'b0;
  logic [PW:0]   wptr_gray = '0;
  logic [PW:0]   rptr_bin;
  logic [PW:0]   rptr_gray;
  logic [PW-1:0] raddr;
  logic          empty;
  logic          almost_empty;
  logic [PW:0]   rd_count;
  logic          underflow;
  logic          underflow_sticky;

  int wbin = 0;
  int n_compared = 0;
  int n_failed = 0;

  int m_rd, m_w1, m_w2, m_count;
  bit m_empty, m_sticky;

  rptr_empty_ctrl #(.PTR_WIDTH(PW), .AE_THRESH(AE)) dut (
    .rclk             (rclk),
    .rrst             (rrst),
    .ren              (ren),
    .clr_underflow    (clr_underflow),
    .wptr_gray        (wptr_gray),
    .rptr_bin         (rptr_bin),
    .rptr_gray        (rptr_gray),
    .raddr            (raddr),
    .empty            (empty),
    .almost_empty     (almost_empty),
    .rd_count         (rd_count),
    .underflow        (underflow),
    .underflow_sticky (underflow_sticky)
  );

  always #5 rclk = ~rclk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit clr, input int w);
    ren           = r;
    clr_underflow = clr;
    wbin          = w & MASK;
    wptr_gray     = 5'((wbin ^ (wbin >> 1)) & MASK);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge rclk);
    #2;
  endtask

  // Model: the write count is seen two edges late and the registered occupancy one
  // edge after that; a read is accepted only when the model says non-empty.
  always @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      m_rd = 0; m_w1 = 0; m_w2 = 0; m_count = 0;
      m_empty = 1'b1; m_sticky = 1'b0;
    end else begin
      if (ren && m_empty) m_sticky = 1'b1;
      else if (clr_underflow) m_sticky = 1'b0;
      if (ren && !m_empty) m_rd = (m_rd + 1) & MASK;
      m_count = (m_w2 - m_rd) & MASK;
      m_empty = (m_count == 0);
      m_w2 = m_w1;
      m_w1 = wbin;
    end
  end

  always @(negedge rclk) begin
    checkOutput("rptr_bin", int'(rptr_bin), m_rd);
    checkOutput("rptr_gray", int'(rptr_gray), (m_rd ^ (m_rd >> 1)) & MASK);
    checkOutput("raddr", int'(raddr), m_rd % (1 << PW));
    checkOutput("rd_count", int'(rd_count), m_count);
    checkOutput("empty", int'(empty), int'(m_empty));
    checkOutput("almost_empty", int'(almost_empty), int'(m_count <= AE));
    checkOutput("underflow", int'(underflow), int'(ren && m_empty));
    checkOutput("underflow_sticky", int'(underflow_sticky), int'(m_sticky));
  end

  initial begin
    int guard;
    applyStimulus(0, 0, 0);
    tick(3);
    checkOutput("reset empty", int'(empty), 1);
    checkOutput("reset almost_empty", int'(almost_empty), 1);
    checkOutput("reset rd_count", int'(rd_count), 0);
    rrst = 1'b0;

    // Synchroniser latency: empty falls on the third edge.
    applyStimulus(0, 0, 1);
    tick(1);
    checkOutput("sync edge1 empty", int'(empty), 1);
    tick(1);
    checkOutput("sync edge2 empty", int'(empty), 1);
    tick(1);
    checkOutput("sync edge3 empty", int'(empty), 0);
    checkOutput("sync rd_count", int'(rd_count), 1);
    checkOutput("sync almost_empty", int'(almost_empty), 1);

    // Drain five entries.
    applyStimulus(0, 0, 5);
    tick(3);
    checkOutput("drain start count", int'(rd_count), 5);
    checkOutput("drain start ae", int'(almost_empty), 0);
    applyStimulus(1, 0, 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("drain raddr", int'(raddr), i);
      tick(1);
      checkOutput("drain rd_count", int'(rd_count), 4 - i);
      checkOutput("drain ae", int'(almost_empty), int'((4 - i) <= AE));
      checkOutput("drain empty", int'(empty), int'(i == 4));
    end

    // Underflow and sticky clear priority.
    tick(1);
    checkOutput("uf rptr hold", int'(rptr_bin), 5);
    checkOutput("uf underflow", int'(underflow), 1);
    checkOutput("uf sticky", int'(underflow_sticky), 1);
    tick(1);
    checkOutput("uf underflow 2", int'(underflow), 1);
    checkOutput("uf rptr hold 2", int'(rptr_bin), 5);
    applyStimulus(1, 1, 5);
    tick(1);
    checkOutput("uf set beats clear", int'(underflow_sticky), 1);
    applyStimulus(0, 1, 5);
    tick(1);
    checkOutput("uf clear", int'(underflow_sticky), 0);

    // Read up to pointer 30, then three entries across the wrap.
    applyStimulus(1, 0, 30);
    guard = 0;
    while (rptr_bin != 5'd30 && guard < 100) begin
      tick(1);
      guard++;
    end
    checkOutput("wrap preload reached", int'(guard < 100), 1);
    applyStimulus(0, 0, 33);
    tick(3);
    checkOutput("wrap count", int'(rd_count), 3);
    checkOutput("wrap gray 30", int'(rptr_gray), 5'b10001);
    applyStimulus(1, 0, 33);
    tick(1);
    checkOutput("wrap bin 31", int'(rptr_bin), 31);
    checkOutput("wrap gray 31", int'(rptr_gray), 5'b10000);
    checkOutput("wrap count 2", int'(rd_count), 2);
    tick(1);
    checkOutput("wrap bin 0", int'(rptr_bin), 0);
    checkOutput("wrap gray 0", int'(rptr_gray), 5'b00000);
    checkOutput("wrap count 1", int'(rd_count), 1);
    tick(1);
    checkOutput("wrap bin 1", int'(rptr_bin), 1);
    checkOutput("wrap gray 1", int'(rptr_gray), 5'b00001);
    checkOutput("wrap count 0", int'(rd_count), 0);
    checkOutput("wrap empty", int'(empty), 1);

    // Advance to pointer 7, then reset mid-stream.
    applyStimulus(0, 0, 8);
    tick(3);
    applyStimulus(1, 0, 8);
    tick(6);
    checkOutput("pre-reset rptr", int'(rptr_bin), 7);
    applyStimulus(0, 0, 8);
    rrst = 1'b1;
    #1;
    checkOutput("mid reset rptr_bin", int'(rptr_bin), 0);
    checkOutput("mid reset rptr_gray", int'(rptr_gray), 0);
    checkOutput("mid reset empty", int'(empty), 1);
    checkOutput("mid reset ae", int'(almost_empty), 1);
    checkOutput("mid reset count", int'(rd_count), 0);
    checkOutput("mid reset sticky", int'(underflow_sticky), 0);
    tick(2);
    rrst = 1'b0;

    // Full occupancy.
    applyStimulus(0, 0, 16);
    tick(3);
    checkOutput("full count", int'(rd_count), 16);
    checkOutput("full empty", int'(empty), 0);
    checkOutput("full ae", int'(almost_empty), 0);
    checkOutput("full rptr", int'(rptr_bin), 0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
